// File: rtl/episode_sequencer.sv
// rtl/episode_sequencer.sv - episode scheduler for the maze Q-learning datapath
// Starts episodes, counts agent steps, detects goal/hole/timeout and decays epsilon.
module episode_sequencer #(
  parameter int                          STATE_W      = 6,
  parameter int                          EP_W         = 10,
  parameter int                          MAX_EPISODES = 256,
  parameter int                          MAX_STEPS    = 15,
  parameter int                          START_STATE  = 1,
  parameter int                          GOAL_STATE   = 25,
  parameter logic [(2**STATE_W)-1:0]     HOLE_MASK    = 64'h0000_0000_0046_41A0,
  parameter logic [15:0]                 EPS_INIT     = 16'hE000,
  parameter int                          EPS_SHIFT    = 4,
  parameter logic [15:0]                 EPS_MIN      = 16'h0800
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic [STATE_W-1:0] state_in,
  input  logic               step_valid,
  output logic               agent_start,
  output logic               agent_en,
  output logic               state_load,
  output logic [STATE_W-1:0] cur_state,
  output logic [EP_W-1:0]    episode,
  output logic [4:0]         step_cnt,
  output logic [EP_W-1:0]    success_cnt,
  output logic [15:0]        epsilon,
  output logic               new_gen,
  output logic               goal_hit,
  output logic               hole_hit,
  output logic               timeout,
  output logic               busy,
  output logic               finish,
  output logic               fail
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_RUN    = 3'd2,
    S_END_EP = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [4:0]         LAST_STEP = 5'(MAX_STEPS - 1);
  localparam logic [EP_W-1:0]    EP_LAST   = EP_W'(MAX_EPISODES);
  localparam logic [STATE_W-1:0] START_S   = STATE_W'(START_STATE);
  localparam logic [STATE_W-1:0] GOAL_S    = STATE_W'(GOAL_STATE);

  state_t      state;
  state_t      state_nxt;
  logic        is_goal;
  logic        is_hole;
  logic        is_last;
  logic        ep_end;
  logic [15:0] eps_dec;
  logic [15:0] eps_next;

  // End check looks at the incoming state and the step count before it increments.
  assign is_goal  = (state_in == GOAL_S);
  assign is_hole  = HOLE_MASK[state_in];
  assign is_last  = (step_cnt == LAST_STEP);
  assign ep_end   = step_valid && (is_goal || is_hole || is_last);
  assign eps_dec  = epsilon - (epsilon >> EPS_SHIFT);
  assign eps_next = (eps_dec < EPS_MIN) ? EPS_MIN : eps_dec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (go) state_nxt = S_START;
      S_START:        state_nxt = S_RUN;
      S_RUN:          if (ep_end) state_nxt = S_END_EP;
      S_END_EP:       state_nxt = (episode == EP_LAST) ? S_DONE : S_START;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    agent_start = (state == S_START);
    new_gen     = (state == S_START);
    state_load  = (state == S_START);
    agent_en    = (state == S_START) || (state == S_RUN);
    busy        = (state == S_START) || (state == S_RUN) || (state == S_END_EP);
    finish      = (state == S_DONE);
    fail        = (state == S_DONE) && (success_cnt == '0);
  end

  // Cause pulses are registered so they appear in the END_EP cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state   <= START_S;
      episode     <= '0;
      step_cnt    <= '0;
      success_cnt <= '0;
      epsilon     <= EPS_INIT;
      goal_hit    <= 1'b0;
      hole_hit    <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      goal_hit <= 1'b0;
      hole_hit <= 1'b0;
      timeout  <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (go) begin
            episode     <= '0;
            success_cnt <= '0;
            epsilon     <= EPS_INIT;
          end
        end
        S_START: begin
          cur_state <= START_S;
          step_cnt  <= '0;
          episode   <= episode + 1'b1;
        end
        S_RUN: begin
          if (step_valid) begin
            cur_state <= state_in;
            step_cnt  <= step_cnt + 5'd1;
            if (is_goal) begin
              goal_hit    <= 1'b1;
              success_cnt <= success_cnt + 1'b1;
            end else if (is_hole) begin
              hole_hit <= 1'b1;
            end else if (is_last) begin
              timeout <= 1'b1;
            end
          end
        end
        S_END_EP: epsilon <= eps_next;
        default: ;
      endcase
    end
  end

endmodule
